tt_um_db_pwm: RTL and testbench

TT_UM_DB_PWM -- requirements
Module: tt_um_db_pwm

---
 rtl/tt_um_db_pwm_pkg.sv | 11 +
 rtl/tt_um_db_pwm_deadtime.sv | 30 +++
 rtl/tt_um_db_pwm.sv | 55 +++++
 tb/tb_tt_um_db_pwm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_db_pwm_pkg.sv
// tt_um_db_pwm_pkg: shared widths, defaults and prescaler mask helper for tt_um_db_pwm
package tt_um_db_pwm_pkg;
    localparam int CNT_W = 8;
    localparam int PRESC_W = 7;
    localparam int PSEL_W = 3;
    localparam int DEADTIME_DEFAULT = 4;
    // Low P bits set: tick when those pcnt bits are all ones (P=0 gives an empty mask, so every clock ticks)
    function automatic logic [PRESC_W-1:0] tick_mask(input logic [PSEL_W-1:0] psel);
        return ~({PRESC_W{1'b1}} << psel);
    endfunction
endpackage

// File: rtl/tt_um_db_pwm_deadtime.sv
// pwm_deadtime: gates complementary outputs until pwm has held its level for DEADTIME clocks
module pwm_deadtime
    import tt_um_db_pwm_pkg::*;
#(
    parameter int DEADTIME = DEADTIME_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic pwm,
    output logic hs,
    output logic ls
);
    localparam logic [3:0] DT = 4'(DEADTIME);
    logic       pwm_q;
    logic [3:0] stable;
    logic       ok;
    // A level that differs from the last registered one is brand new, so both sides drop at once
    assign ok = (pwm == pwm_q) && (stable >= DT);
    assign hs = pwm && ok;
    assign ls = !pwm && ok;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pwm_q  <= 1'b0;
            stable <= '0;
        end else if (ena) begin
            pwm_q  <= pwm;
            stable <= (pwm != pwm_q) ? 4'd1 : (stable == 4'hF) ? stable : stable + 4'd1;
        end
endmodule

// File: rtl/tt_um_db_pwm.sv
// tt_um_db_pwm: prescaled 8-bit PWM with period pulse; define PWM_DEADTIME_EN for a dead band on hs/ls
module tt_um_db_pwm
    import tt_um_db_pwm_pkg::*;
#(
    parameter int DEADTIME = DEADTIME_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [PRESC_W-1:0] pcnt, pmask;
    logic [CNT_W-1:0]   cnt, duty_reg;
    logic tick, wrap, pulse, pwm, hs, ls, unused;
    assign pmask = tick_mask(uio_in[PSEL_W-1:0]);
    assign tick  = (pcnt & pmask) == pmask;
    assign wrap  = ena && tick && (cnt == '1);
    assign pwm   = (cnt < duty_reg) ^ uio_in[3];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pcnt     <= '0;
            cnt      <= '0;
            duty_reg <= '0;
            pulse    <= 1'b0;
        end else begin
            pulse <= wrap;
            if (ena) begin
                pcnt <= pcnt + 1'b1;
                if (tick) cnt <= cnt + 1'b1;
                if (wrap) duty_reg <= ui_in;
            end
        end
`ifdef PWM_DEADTIME_EN
    pwm_deadtime #(.DEADTIME(DEADTIME)) u_dt (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .pwm  (pwm),
        .hs   (hs),
        .ls   (ls)
    );
    assign unused = &{1'b0, uio_in[7:4]};
`else
    assign hs = pwm;
    assign ls = ~pwm;
    assign unused = &{1'b0, uio_in[7:4], DEADTIME[0]};
`endif
    assign uo_out  = {cnt[7:3], pulse, ls, hs};
    assign uio_out = {duty_reg[7:4], 4'b0};
    assign uio_oe  = 8'hF0;
endmodule

// File: tb/tb_tt_um_db_pwm.sv
// tb_tt_um_db_pwm: randomized self-checking bench for tt_um_db_pwm against a period/duty reference model
module tb_tt_um_db_pwm;
    localparam int DT = 4;
`ifdef PWM_DEADTIME_EN
    localparam bit DT_EN = 1'b1;
`else
    localparam bit DT_EN = 1'b0;
`endif
    localparam int DT_LOSS = DT_EN ? DT : 0;

    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
    logic [7:0] ui_in = '0, uio_in = '0;
    logic [7:0] uo_out, uio_out, uio_oe;

    always #5 clk = ~clk;

    tt_um_db_pwm #(.DEADTIME(DT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    int n_chk = 0, n_pass = 0;
    int n, p_m, per, cyc_n = 0, last_p = 0, gap = 0, vec_bad = 0;
    int acc_hs, acc_lo, acc_pulse, acc_both_lo, acc_both_hi;
    logic [7:0]  duty_m;
    logic        pulse_m;
    logic [23:0] vec_got, vec_exp, bad_got, bad_exp;
    logic [4:0]  cnt_hi_exp;
    logic [1:0]  lo_exp;
    bit hist[$];

    // n counts enabled clocks since reset; with P fixed, the period position is n / 2^P
    function automatic logic pwm_now();
        int c;
        c = (n >> p_m) % 256;
        return ((c < int'(duty_m)) ? 1'b1 : 1'b0) ^ uio_in[3];
    endfunction

    // Sides are enabled once the last DT levels seen at enabled edges agree with the present level
    function automatic logic [23:0] expected();
        int c;
        logic p, ok, hs, ls;
        logic [7:0] cb;
        c  = (n >> p_m) % 256;
        cb = 8'(c);
        p  = pwm_now();
        ok = hist.size() >= DT && p == hist[$];
        if (ok) for (int i = 1; i < DT; i++) if (hist[hist.size() - 1 - i] != hist[$]) ok = 1'b0;
        hs = DT_EN ? (p & ok) : p;
        ls = DT_EN ? (!p & ok) : !p;
        return {cb[7:3], pulse_m, ls, hs, duty_m[7:4], 4'h0, 8'hF0};
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (ena) begin
            hist.push_back(pwm_now());
            if (hist.size() > 16) void'(hist.pop_front());
            pulse_m = (n % per) == per - 1;
            if (pulse_m) duty_m = ui_in;
            n++;
        end else pulse_m = 1'b0;
        @(negedge clk);
        cyc_n++;
        vec_got = {uo_out, uio_out, uio_oe};
        vec_exp = expected();
        if (vec_got !== vec_exp) begin
            if (vec_bad == 0) begin
                bad_got = vec_got;
                bad_exp = vec_exp;
            end
            vec_bad++;
        end
        acc_hs      += int'(uo_out[0] === 1'b1);
        acc_lo      += int'(uo_out[0] === 1'b0);
        acc_pulse   += int'(uo_out[2] === 1'b1);
        acc_both_lo += int'(uo_out[1:0] === 2'b00);
        acc_both_hi += int'(uo_out[1:0] === 2'b11);
        if (uo_out[2] === 1'b1) begin
            gap    = cyc_n - last_p;
            last_p = cyc_n;
        end
    endtask

    task automatic clr_acc();
        acc_hs = 0; acc_lo = 0; acc_pulse = 0; acc_both_lo = 0; acc_both_hi = 0;
    endtask

    task automatic do_reset(input int p, input bit inv, input logic [7:0] d);
        @(negedge clk);
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = d;
        uio_in = {4'($urandom), inv, 3'(p)};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0; p_m = p; per = 256 << p; duty_m = '0; pulse_m = 1'b0;
        hist.delete();
        last_p = cyc_n; vec_bad = 0;
        clr_acc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'hFF; uio_in = 8'h00;
        repeat (3) @(negedge clk);
        n_chk++; if (uo_out[0] !== 1'b0) $display("FAIL rst_hs: got %b expected 0", uo_out[0]); else n_pass++;
        n_chk++; if (uo_out[2] !== 1'b0) $display("FAIL rst_pulse: got %b expected 0", uo_out[2]); else n_pass++;
        n_chk++; if (uo_out[7:3] !== 5'd0) $display("FAIL rst_cnt: got %h expected 0", uo_out[7:3]); else n_pass++;
        n_chk++; if (uio_out !== 8'h00) $display("FAIL rst_uio_out: got %h expected 00", uio_out); else n_pass++;
        n_chk++; if (uio_oe !== 8'hF0) $display("FAIL rst_uio_oe: got %h expected f0", uio_oe); else n_pass++;
        do_reset(0, 1'b0, 8'hFF);
        repeat (255) cyc();
        n_chk++; if (acc_hs !== 0) $display("FAIL rst_first_period_high: got %0d expected 0", acc_hs); else n_pass++;
        cyc();
        n_chk++; if (uio_out !== 8'hF0) $display("FAIL rst_duty_load: got %h expected f0", uio_out); else n_pass++;
        n_chk++; if (vec_bad !== 0) $display("FAIL reset_model: %0d cycles differ, first got %h expected %h", vec_bad, bad_got, bad_exp); else n_pass++;
    endtask

    task automatic test_duty64();
        do_reset(0, 1'b0, 8'd64);
        repeat (255) cyc();
        for (int k = 0; k < 2; k++) begin
            clr_acc();
            repeat (256) cyc();
            n_chk++; if (acc_hs !== 64 - DT_LOSS) $display("FAIL duty64_high[%0d]: got %0d expected %0d", k, acc_hs, 64 - DT_LOSS); else n_pass++;
            n_chk++; if (acc_pulse !== 1) $display("FAIL duty64_pulses[%0d]: got %0d expected 1", k, acc_pulse); else n_pass++;
        end
        n_chk++; if (gap !== 256) $display("FAIL duty64_period: got %0d expected 256", gap); else n_pass++;
        n_chk++; if (vec_bad !== 0) $display("FAIL duty64_model: %0d cycles differ, first got %h expected %h", vec_bad, bad_got, bad_exp); else n_pass++;
    endtask

    task automatic test_zero_full();
        do_reset(0, 1'b0, 8'd0);
        repeat (255) cyc();
        clr_acc();
        repeat (256) cyc();
        n_chk++; if (acc_hs !== 0) $display("FAIL duty0_high: got %0d expected 0", acc_hs); else n_pass++;
        ui_in = 8'd255;
        clr_acc();
        repeat (256) cyc();
        n_chk++; if (acc_lo !== 1 + DT_LOSS) $display("FAIL duty255_low: got %0d expected %0d", acc_lo, 1 + DT_LOSS); else n_pass++;
        n_chk++; if (vec_bad !== 0) $display("FAIL zero_full_model: %0d cycles differ, first got %h expected %h", vec_bad, bad_got, bad_exp); else n_pass++;
    endtask

    task automatic test_prescale();
        do_reset(2, 1'b0, 8'd32);
        repeat (1023) cyc();
        clr_acc();
        repeat (1024) cyc();
        n_chk++; if (acc_hs !== 128 - DT_LOSS) $display("FAIL presc_high: got %0d expected %0d", acc_hs, 128 - DT_LOSS); else n_pass++;
        n_chk++; if (acc_pulse !== 1) $display("FAIL presc_pulses: got %0d expected 1", acc_pulse); else n_pass++;
        clr_acc();
        cyc();
        n_chk++; if (gap !== 1024) $display("FAIL presc_period: got %0d expected 1024", gap); else n_pass++;
        repeat (299) cyc();
        ena = 1'b0;
        repeat (50) cyc();
        cnt_hi_exp = 5'(((n >> 2) % 256) >> 3);
        n_chk++; if (uo_out[7:3] !== cnt_hi_exp) $display("FAIL presc_frozen_cnt: got %h expected %h", uo_out[7:3], cnt_hi_exp); else n_pass++;
        ena = 1'b1;
        repeat (724) cyc();
        n_chk++; if (acc_hs !== 128 - DT_LOSS) $display("FAIL presc_stretch_high: got %0d expected %0d", acc_hs, 128 - DT_LOSS); else n_pass++;
        cyc();
        n_chk++; if (gap !== 1074) $display("FAIL presc_stretch_period: got %0d expected 1074", gap); else n_pass++;
        n_chk++; if (vec_bad !== 0) $display("FAIL prescale_model: %0d cycles differ, first got %h expected %h", vec_bad, bad_got, bad_exp); else n_pass++;
    endtask

    task automatic test_duty_change();
        do_reset(0, 1'b0, 8'd64);
        repeat (255) cyc();
        clr_acc();
        repeat (11) cyc();
        ui_in = 8'd200;
        n_chk++; if (uio_out[7:4] !== 4'h4) $display("FAIL chg_duty_mid: got %h expected 4", uio_out[7:4]); else n_pass++;
        repeat (245) cyc();
        n_chk++; if (acc_hs !== 64 - DT_LOSS) $display("FAIL chg_old_high: got %0d expected %0d", acc_hs, 64 - DT_LOSS); else n_pass++;
        n_chk++; if (uio_out[7:4] !== 4'h4) $display("FAIL chg_duty_end: got %h expected 4", uio_out[7:4]); else n_pass++;
        clr_acc();
        repeat (256) cyc();
        n_chk++; if (acc_hs !== 200 - DT_LOSS) $display("FAIL chg_new_high: got %0d expected %0d", acc_hs, 200 - DT_LOSS); else n_pass++;
        n_chk++; if (uio_out[7:4] !== 4'hC) $display("FAIL chg_duty_new: got %h expected c", uio_out[7:4]); else n_pass++;
        n_chk++; if (vec_bad !== 0) $display("FAIL duty_change_model: %0d cycles differ, first got %h expected %h", vec_bad, bad_got, bad_exp); else n_pass++;
    endtask

    task automatic test_deadtime();
        do_reset(0, 1'b0, 8'd128);
        repeat (255) cyc();
        clr_acc();
        repeat (256) cyc();
        n_chk++; if (acc_both_lo !== 2 * DT_LOSS) $display("FAIL dt_both_low: got %0d expected %0d", acc_both_lo, 2 * DT_LOSS); else n_pass++;
        n_chk++; if (acc_both_hi !== 0) $display("FAIL dt_both_high: got %0d expected 0", acc_both_hi); else n_pass++;
        n_chk++; if (acc_hs !== 128 - DT_LOSS) $display("FAIL dt_high: got %0d expected %0d", acc_hs, 128 - DT_LOSS); else n_pass++;
        uio_in[3] = 1'b1;
        #1;
        vec_exp = expected();
        lo_exp  = vec_exp[17:16];
        n_chk++; if (uo_out[1:0] !== lo_exp) $display("FAIL inv_immediate: got %b expected %b", uo_out[1:0], lo_exp); else n_pass++;
        clr_acc();
        repeat (512) cyc();
        n_chk++; if (acc_both_hi !== 0) $display("FAIL dt_inv_both_high: got %0d expected 0", acc_both_hi); else n_pass++;
        n_chk++; if (vec_bad !== 0) $display("FAIL deadtime_model: %0d cycles differ, first got %h expected %h", vec_bad, bad_got, bad_exp); else n_pass++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            do_reset(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            clr_acc();
            repeat (1500) begin
                if ($urandom_range(0, 63) == 0) ui_in = 8'($urandom);
                if ($urandom_range(0, 199) == 0) uio_in[3] = ~uio_in[3];
                if ($urandom_range(0, 31) == 0) uio_in[7:4] = 4'($urandom);
                ena = ($urandom_range(0, 49) != 0);
                cyc();
            end
            ena = 1'b1;
            n_chk++; if (acc_both_hi !== 0) $display("FAIL rand_both_high[%0d]: got %0d expected 0", r, acc_both_hi); else n_pass++;
            n_chk++; if (vec_bad !== 0) $display("FAIL rand_model[%0d]: %0d cycles differ, first got %h expected %h", r, vec_bad, bad_got, bad_exp); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_duty64();
        test_zero_full();
        test_prescale();
        test_duty_change();
        test_deadtime();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
